// File: rtl/dm_dma.sv
`default_nettype none
// ============================================================================
// Module   : dm_dma
// Purpose  : Byte-block copy/fill engine mastering the data-memory port.
// Revision : 1.0
// ============================================================================
module dm_dma #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_mode,
    input  logic [ADDR_W-1:0] i_src,
    input  logic [ADDR_W-1:0] i_dst,
    input  logic [ADDR_W-1:0] i_len,
    input  logic [DATA_W-1:0] i_fill_val,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_ea,
    output logic [DATA_W-1:0] o_result,
    output logic              o_mem_en,
    input  logic [DATA_W-1:0] i_data
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_READ  = 2'd1;
    localparam logic [1:0] c_WRITE = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic [ADDR_W-1:0] r_sp;
    logic [ADDR_W-1:0] r_dp;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_md;
    logic [DATA_W-1:0] r_fv;
    logic [DATA_W-1:0] r_buf;
    logic              w_last;

    assign w_last = (r_cnt == ADDR_W'(1));

    // State register and datapath; operands are captured only on an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_sp    <= '0;
            r_dp    <= '0;
            r_cnt   <= '0;
            r_md    <= 1'b0;
            r_fv    <= '0;
            r_buf   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                c_IDLE: begin
                    if (i_start) begin
                        r_sp  <= i_src;
                        r_dp  <= i_dst;
                        r_cnt <= i_len;
                        r_md  <= i_mode;
                        r_fv  <= i_fill_val;
                    end
                end
                c_READ: r_buf <= i_data;
                c_WRITE: begin
                    r_sp  <= r_sp + ADDR_W'(1);
                    r_dp  <= r_dp + ADDR_W'(1);
                    r_cnt <= r_cnt - ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (i_start) begin
                    if (i_len == '0)
                        w_next = c_DONE;
                    else if (i_mode)
                        w_next = c_WRITE;
                    else
                        w_next = c_READ;
                end
            end
            c_READ:  w_next = c_WRITE;
            c_WRITE: begin
                if (w_last)
                    w_next = c_DONE;
                else if (r_md)
                    w_next = c_WRITE;
                else
                    w_next = c_READ;
            end
            default: w_next = c_IDLE;
        endcase
    end

    always_comb begin
        o_busy   = 1'b0;
        o_done   = 1'b0;
        o_ea     = '0;
        o_result = '0;
        o_mem_en = 1'b0;
        case (r_state)
            c_READ: begin
                o_busy = 1'b1;
                o_ea   = r_sp;
            end
            c_WRITE: begin
                o_busy   = 1'b1;
                o_ea     = r_dp;
                o_result = r_md ? r_fv : r_buf;
                o_mem_en = 1'b1;
            end
            c_DONE:  o_done = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/dm_dma.md
# dm_dma

Byte-block transfer engine that acts as the initiator on the data-memory port: it drives `ea`, `result` and `mem_en` and samples `data`, just as the CPU datapath does. It copies `len` bytes from `src` to `dst`, or fills `len` bytes at `dst` with a constant, autonomously. It sits beside the CPU. While `busy` is high the top-level memory mux gives the data-memory port to this block.

## Interface
- `ADDR_W`, default 8: address width; the address space is 2^ADDR_W bytes.
- `DATA_W`, default 8: data width.

Ports (all active-high):
- `clk`  in  1  clock; the block uses rising edges only.
- `rst`  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `start`  in  1  launches a transfer; sampled only in IDLE.
- `mode`  in  1  0 = copy, 1 = fill. Latched on accepted `start`.
- `src`  in  ADDR_W  copy source base address. Latched on accepted `start`; ignored in fill mode.
- `dst`  in  ADDR_W  destination base address. Latched on accepted `start`.
- `len`  in  ADDR_W  byte count, 0..255. Latched on accepted `start`.
- `fill_val`  in  DATA_W  fill byte. Latched on accepted `start`.
- `busy`  out  1  high in the READ and WRITE states.
- `done`  out  1  one-cycle pulse in the DONE state.
- `ea`  out  ADDR_W  memory address.
- `result`  out  DATA_W  memory write data.
- `mem_en`  out  1  memory write enable.
- `data`  in  DATA_W  memory read data. This is combinational from `ea`, with no read latency.

## Operation
- The state machine has four states: IDLE, READ, WRITE, DONE. The state is registered, and outputs are decoded from the state and the datapath registers.
- **IDLE.** `ea`=0, `result`=0, `mem_en`=0, `busy`=0, `done`=0.
  - On `start`, latch the operands: `sp`←`src`, `dp`←`dst`, `cnt`←`len`, `md`←`mode`, `fv`←`fill_val`.
  - Next state is DONE if `len`=0, otherwise WRITE if `mode`=1, otherwise READ.
- **READ** (copy only). `ea`=`sp`, `mem_en`=0.
  - At the rising edge, capture `data` into `buf`, then go to WRITE.
- **WRITE.** `ea`=`dp`, `result` = (`md` ? `fv` : `buf`), `mem_en`=1. The memory commits the write on the falling edge inside this cycle.
  - At the rising edge, `dp`←`dp`+1, `sp`←`sp`+1 and `cnt`←`cnt`−1.
  - If `cnt`=1, go to DONE. Otherwise go to READ (copy) or stay in WRITE (fill).
- **DONE.** `done`=1 and `mem_en`=0, then go to IDLE unconditionally.
- **Address arithmetic.** Pointers are ADDR_W bits and wrap modulo 2^ADDR_W (0xFF+1 → 0x00). There is no error on wrap.
- **Overlapping copies.** Copies are strictly forward, one byte at a time. With `dst`=`src`+1, every destination byte receives the original `src` byte; this replication is defined behaviour. With `dst`=`src`, each byte is rewritten with its own value.
- **`start` while not IDLE.** Ignored. A `start` present in the DONE cycle is also ignored.
- **Operand changes during a transfer.** Changes to `src`, `dst`, `len`, `mode` or `fill_val` while busy have no effect.
- **Reset.** `rst` at any rising edge forces IDLE and clears all registers to 0; an in-flight transfer is abandoned.
  - Bytes already written stay written, unless the memory's own reset clears them.
  - The write for a WRITE cycle whose ending edge carries `rst` still occurs, because the falling edge precedes the reset edge.

## Timing
- Reset value of every output: `busy`=0, `done`=0, `ea`=0, `result`=0, `mem_en`=0.
- Let cycle 0 be the cycle in which `start` is sampled. The first READ or WRITE is cycle 1.
- Copy of N bytes:
  - `busy` is high for cycles 1..2N.
  - WRITE occurs in the even cycles 2k, for k=1..N.
  - `done` pulses in cycle 2N+1; a new `start` is accepted in cycle 2N+2.
- Fill of N bytes:
  - `busy` is high for cycles 1..N, and `mem_en` is high for those N consecutive cycles.
  - `done` pulses in cycle N+1.
- `len`=0: no memory access, `busy` never rises, and `done` pulses in cycle 1.
- `len`=255 with copy: 510 busy cycles. This is the maximum transfer.
- `mem_en` is high only in WRITE. `ea` and `result` are stable for the whole WRITE cycle.

## Test plan
- **Copy.** Preload mem[0x10..0x12] = 0xA1, 0xB2, 0xC3. Start copy with `src`=0x10, `dst`=0x40, `len`=3.
  - Required: mem[0x40..0x42] = 0xA1, 0xB2, 0xC3.
  - `busy` is high for 6 cycles and `done` pulses in cycle 7.
  - `mem_en` is high only in cycles 2, 4 and 6.
- **Fill with wrap.** Fill with `dst`=0xFE, `len`=4, `fill_val`=0x5A.
  - Required: mem[0xFE], mem[0xFF], mem[0x00] and mem[0x01] all equal 0x5A; mem[0x02] is untouched.
  - `done` pulses in cycle 5.
- **Zero length.** `len`=0 in either mode.
  - Required: `mem_en` never asserts, `busy` stays 0, and `done` pulses in cycle 1.
- **Overlapping copy.** Preload mem[0x20..0x23] = 0x01, 0x02, 0x03, 0x04. Copy with `src`=0x20, `dst`=0x21, `len`=3.
  - Required: mem[0x21..0x23] = 0x01, 0x01, 0x01.
- **Start while busy.** Start a copy with `len`=5, then pulse `start` with new operands at cycles 3 and 11 (the DONE cycle).
  - Required: both pulses are ignored, and only the original 5 bytes are written.
- **Reset mid-transfer.** Start a fill with `len`=10 and assert `rst` at the edge that ends cycle 4.
  - Required: exactly 4 bytes are written.
  - From the next cycle: `busy`=0, `mem_en`=0, `ea`=0, and no `done` pulse.
  - A fresh `start` afterwards completes normally.
